// File: rtl/hazard_forward_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_if
//
// Bundles the decode-side and pipeline-side signals of the hazard/forwarding
// unit into one interface.
//
// Handshake semantics: dec_valid qualifies every dec_* field in the same
// cycle. mem_ready is a global "advance" strobe: when 0 the whole pipeline
// is frozen and nothing moves. An instruction leaves decode on a rising edge
// where mem_ready=1 and stall=0. There is no other ready signal.
//
// Modports:
//   master : driven by the decoder / pipeline control (owns all inputs)
//   slave  : the hazard_forward_unit (owns the resolved operands and enables)
//
// Signals:
//   dec_valid, dec_rd, dec_rd_we, dec_is_load  decode-stage instruction fields
//   dec_rs, dec_rs_used                        source indices and slot usage
//   dec_operand                                register-file operands per slot
//   stage_result                               result bus of stages 1..FWD_DEPTH
//   mem_ready, flush                           freeze / squash controls
//   fwd_operand, fwd_sel                       resolved operands and their sources
//   stall, f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble  pipeline control
// -----------------------------------------------------------------------------
interface hazard_forward_unit_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 3
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                          dec_valid;
    logic [REG_ADDR_W-1:0]         dec_rd;
    logic                          dec_rd_we;
    logic                          dec_is_load;
    logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs;
    logic [NUM_SRC-1:0]            dec_rs_used;
    logic [NUM_SRC*XLEN-1:0]       dec_operand;
    logic [FWD_DEPTH*XLEN-1:0]     stage_result;
    logic                          mem_ready;
    logic                          flush;

    logic [NUM_SRC*XLEN-1:0]       fwd_operand;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;
    logic                          f_to_d_enable_ff;
    logic                          d_to_e_enable_ff;
    logic                          d_to_e_bubble;

    modport master (
        output dec_valid, dec_rd, dec_rd_we, dec_is_load, dec_rs, dec_rs_used,
               dec_operand, stage_result, mem_ready, flush,
        input  fwd_operand, fwd_sel, stall, f_to_d_enable_ff, d_to_e_enable_ff,
               d_to_e_bubble
    );

    modport slave (
        input  dec_valid, dec_rd, dec_rd_we, dec_is_load, dec_rs, dec_rs_used,
               dec_operand, stage_result, mem_ready, flush,
        output fwd_operand, fwd_sel, stall, f_to_d_enable_ff, d_to_e_enable_ff,
               d_to_e_bubble
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Decode-stage hazard detection and operand forwarding. A shift-register
// tracker remembers the last FWD_DEPTH instructions that left decode
// (entry 1 = execute). Each source slot of the decoding instruction picks
// the youngest tracked producer of its register; a load that is still too
// young to have data produces a load-use stall and a bubble.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, adds saturating 32-bit counters perf_stall_cycles and
//   perf_fwd_events, both cleared by rst.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset; invalidates every tracker entry
//   bus   hazard_forward_unit_if.slave (decode fields, stage results,
//         mem_ready/flush in; resolved operands, fwd_sel, stall and
//         pipeline enables/bubble out)
//   perf_stall_cycles, perf_fwd_events   (HAZARD_PERF_CNT_EN only)
//
// All outputs are combinational from the tracker and current inputs.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int XLEN             = 64,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_fwd_events
`endif
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    // Tracker entries, index 1 = execute stage.
    logic [FWD_DEPTH:1]    t_valid;
    logic [FWD_DEPTH:1]    t_we;
    logic [FWD_DEPTH:1]    t_load;
    logic [REG_ADDR_W-1:0] t_rd [1:FWD_DEPTH];

    logic [NUM_SRC-1:0]       load_hazard;
    logic [NUM_SRC*SEL_W-1:0] sel_c;
    logic [NUM_SRC*XLEN-1:0]  operand_c;
    logic                     stall_c;

    logic                  found;
    logic                  found_load;
    int                    found_k;
    logic [XLEN-1:0]       found_op;
    logic [REG_ADDR_W-1:0] rs;

    always_comb begin
        load_hazard = '0;
        sel_c       = '0;
        operand_c   = bus.dec_operand;
        found       = 1'b0;
        found_load  = 1'b0;
        found_k     = 0;
        found_op    = '0;
        rs          = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs         = bus.dec_rs[s*REG_ADDR_W +: REG_ADDR_W];
            found      = 1'b0;
            found_load = 1'b0;
            found_k    = 0;
            found_op   = '0;
            // Scan oldest to youngest so the youngest match is the one left.
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (bus.dec_valid && bus.dec_rs_used[s] && t_valid[k] && t_we[k] &&
                    (t_rd[k] != '0) && (t_rd[k] == rs)) begin
                    found      = 1'b1;
                    found_load = t_load[k];
                    found_k    = k;
                    found_op   = bus.stage_result[(k-1)*XLEN +: XLEN];
                end
            end
            if (found) begin
                if (found_load && (found_k < LOAD_READY_STAGE)) begin
                    // Load data not yet available; the slot keeps its
                    // register-file defaults while the instruction waits.
                    load_hazard[s] = 1'b1;
                end else begin
                    sel_c[s*SEL_W +: SEL_W]    = SEL_W'(found_k);
                    operand_c[s*XLEN +: XLEN] = found_op;
                end
            end
        end
    end

    // A flushed instruction never needs its operands, so flush hides stalls.
    assign stall_c = (|load_hazard) & ~bus.flush;

    assign bus.fwd_operand      = operand_c;
    assign bus.fwd_sel          = sel_c;
    assign bus.stall            = stall_c;
    assign bus.f_to_d_enable_ff = bus.mem_ready & ~stall_c;
    assign bus.d_to_e_enable_ff = bus.mem_ready;
    assign bus.d_to_e_bubble    = stall_c | bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_valid <= '0;
            t_we    <= '0;
            t_load  <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                t_rd[k] <= '0;
            end
        end else if (bus.mem_ready) begin
            if (stall_c || bus.flush) begin
                t_valid[1] <= 1'b0;
                t_we[1]    <= 1'b0;
                t_load[1]  <= 1'b0;
                t_rd[1]    <= '0;
            end else begin
                t_valid[1] <= bus.dec_valid;
                t_we[1]    <= bus.dec_rd_we;
                t_load[1]  <= bus.dec_is_load;
                t_rd[1]    <= bus.dec_rd;
            end
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                t_valid[k] <= t_valid[k-1];
                t_we[k]    <= t_we[k-1];
                t_load[k]  <= t_load[k-1];
                t_rd[k]    <= t_rd[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    int          fwd_n;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_n = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sel_c[s*SEL_W +: SEL_W] != '0) begin
                fwd_n = fwd_n + 1;
            end
        end
    end

    assign fwd_sum = {1'b0, perf_fwd_events} + 33'(fwd_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_fwd_events   <= '0;
        end else begin
            if (stall_c && bus.mem_ready && !(&perf_stall_cycles)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bus.mem_ready && !stall_c) begin
                perf_fwd_events <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Two instances share one decode stream: u2 with LOAD_READY_STAGE=2 and
// u3 with LOAD_READY_STAGE=3. Directed tasks check the documented scenarios
// with constant expectations; the random task compares both instances with
// a history-list reference model every cycle.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;
    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int NS   = 2;
    localparam int FD   = 3;
    localparam int SW   = $clog2(FD + 1);

    localparam logic [XLEN-1:0] SR1 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [XLEN-1:0] SR2 = 64'h2222_2222_2222_2222;
    localparam logic [XLEN-1:0] SR3 = 64'h3333_3333_3333_3333;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 dec_valid, dec_rd_we, dec_is_load, mem_ready, flush;
    logic [RW-1:0]        dec_rd;
    logic [NS*RW-1:0]     dec_rs;
    logic [NS-1:0]        dec_rs_used;
    logic [NS*XLEN-1:0]   dec_operand;
    logic [FD*XLEN-1:0]   stage_result;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_DEPTH(FD)) bus2 ();
    hazard_forward_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_DEPTH(FD)) bus3 ();

    assign bus2.dec_valid = dec_valid;      assign bus3.dec_valid = dec_valid;
    assign bus2.dec_rd = dec_rd;            assign bus3.dec_rd = dec_rd;
    assign bus2.dec_rd_we = dec_rd_we;      assign bus3.dec_rd_we = dec_rd_we;
    assign bus2.dec_is_load = dec_is_load;  assign bus3.dec_is_load = dec_is_load;
    assign bus2.dec_rs = dec_rs;            assign bus3.dec_rs = dec_rs;
    assign bus2.dec_rs_used = dec_rs_used;  assign bus3.dec_rs_used = dec_rs_used;
    assign bus2.dec_operand = dec_operand;  assign bus3.dec_operand = dec_operand;
    assign bus2.stage_result = stage_result; assign bus3.stage_result = stage_result;
    assign bus2.mem_ready = mem_ready;      assign bus3.mem_ready = mem_ready;
    assign bus2.flush = flush;              assign bus3.flush = flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] p2_stall, p2_fwd, p3_stall, p3_fwd;
`endif

    hazard_forward_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_DEPTH(FD),
                          .LOAD_READY_STAGE(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(p2_stall), .perf_fwd_events(p2_fwd)
`endif
    );

    hazard_forward_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_DEPTH(FD),
                          .LOAD_READY_STAGE(3)) u3 (
        .clk(clk), .rst(rst), .bus(bus3)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(p3_stall), .perf_fwd_events(p3_fwd)
`endif
    );

    // Per-instance views of the DUT outputs (index 0 = u2, 1 = u3).
    logic [SW-1:0]   sel_a [2][NS];
    logic [XLEN-1:0] op_a  [2][NS];
    logic            stall_a [2];
    logic            bub_a   [2];
    logic            fde_a   [2];
    logic            dee_a   [2];

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            sel_a[0][s] = bus2.fwd_sel[s*SW +: SW];
            sel_a[1][s] = bus3.fwd_sel[s*SW +: SW];
            op_a[0][s]  = bus2.fwd_operand[s*XLEN +: XLEN];
            op_a[1][s]  = bus3.fwd_operand[s*XLEN +: XLEN];
        end
        stall_a[0] = bus2.stall;            stall_a[1] = bus3.stall;
        bub_a[0]   = bus2.d_to_e_bubble;    bub_a[1]   = bus3.d_to_e_bubble;
        fde_a[0]   = bus2.f_to_d_enable_ff; fde_a[1]   = bus3.f_to_d_enable_ff;
        dee_a[0]   = bus2.d_to_e_enable_ff; dee_a[1]   = bus3.d_to_e_enable_ff;
    end

    // ---------------- reference model ----------------
    // hist[w][0] is the most recent instruction to leave decode.
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          we;
        logic          ld;
    } ent_t;

    ent_t            hist    [2][FD];
    logic [NS-1:0]   exp_haz [2];
    logic            exp_stall [2];
    int              exp_sel [2][NS];
    logic [XLEN-1:0] exp_op  [2][NS];

    function automatic void model_eval(int w);
        int lrs;
        int hit;
        logic [RW-1:0] rs;
        lrs = (w == 0) ? 2 : 3;
        exp_haz[w] = '0;
        for (int s = 0; s < NS; s++) begin
            rs  = dec_rs[s*RW +: RW];
            hit = 0;
            exp_sel[w][s] = 0;
            exp_op[w][s]  = dec_operand[s*XLEN +: XLEN];
            if (dec_valid && dec_rs_used[s] && rs != 0) begin
                for (int k = 1; k <= FD; k++) begin
                    if (hit == 0 && hist[w][k-1].v && hist[w][k-1].we && hist[w][k-1].rd == rs)
                        hit = k;
                end
            end
            if (hit != 0) begin
                if (hist[w][hit-1].ld && hit < lrs) begin
                    exp_haz[w][s] = 1'b1;
                end else begin
                    exp_sel[w][s] = hit;
                    exp_op[w][s]  = stage_result[(hit-1)*XLEN +: XLEN];
                end
            end
        end
        exp_stall[w] = (|exp_haz[w]) && !flush;
    endfunction

    function automatic void model_step(int w);
        ent_t e;
        if (rst) begin
            for (int k = 0; k < FD; k++) hist[w][k] = '0;
        end else if (mem_ready) begin
            for (int k = FD - 1; k >= 1; k--) hist[w][k] = hist[w][k-1];
            if (exp_stall[w] || flush) begin
                e = '0;
            end else begin
                e.v = dec_valid; e.rd = dec_rd; e.we = dec_rd_we; e.ld = dec_is_load;
            end
            hist[w][0] = e;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic set_instr(input logic v, input int rd, input logic we, input logic ld,
                             input int rs0, input int rs1, input logic [1:0] used);
        dec_valid   = v;
        dec_rd      = RW'(rd);
        dec_rd_we   = we;
        dec_is_load = ld;
        dec_rs      = {RW'(rs1), RW'(rs0)};
        dec_rs_used = used;
        dec_operand = {$urandom, $urandom, $urandom, $urandom};
        #1;
    endtask

    task automatic drain();
        set_instr(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b00);
        repeat (FD) tick();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; flush = 1'b0;
        stage_result = {SR3, SR2, SR1};
        for (int k = 0; k < FD; k++) begin hist[0][k] = '0; hist[1][k] = '0; end
        set_instr(1'b1, 3, 1'b1, 1'b0, 1, 2, 2'b11);
        tick(); tick();
        rst = 1'b0;
        set_instr(1'b1, 3, 1'b1, 1'b0, 1, 2, 2'b11);
        if (stall_a[0] !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_a[0]); end checks++;
        if (sel_a[0][0] !== '0 || sel_a[0][1] !== '0) begin errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", sel_a[0][0], sel_a[0][1]); end checks++;
        if (op_a[0][0] !== dec_operand[XLEN-1:0] || op_a[0][1] !== dec_operand[2*XLEN-1:XLEN]) begin errors++; $display("FAIL reset_operand: got %h/%h want %h", op_a[0][0], op_a[0][1], dec_operand); end checks++;
        if (bub_a[0] !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0b want 0", bub_a[0]); end checks++;
        if (fde_a[0] !== 1'b1 || dee_a[0] !== 1'b1) begin errors++; $display("FAIL reset_enables: got %0b%0b want 11", fde_a[0], dee_a[0]); end checks++;
        mem_ready = 1'b0; #1;
        if (fde_a[0] !== 1'b0 || dee_a[0] !== 1'b0) begin errors++; $display("FAIL reset_enables_busy: got %0b%0b want 00", fde_a[0], dee_a[0]); end checks++;
        mem_ready = 1'b1; #1;
        tick();
    endtask

    task automatic test_forward();
        set_instr(1'b1, 5, 1'b1, 1'b0, 1, 2, 2'b11);
        tick();
        set_instr(1'b1, 6, 1'b1, 1'b0, 5, 2, 2'b11);
        if (sel_a[0][0] !== SW'(1)) begin errors++; $display("FAIL fwd_sel0: got %0d want 1", sel_a[0][0]); end checks++;
        if (op_a[0][0] !== SR1) begin errors++; $display("FAIL fwd_op0: got %h want %h", op_a[0][0], SR1); end checks++;
        if (sel_a[0][1] !== '0 || op_a[0][1] !== dec_operand[2*XLEN-1:XLEN]) begin errors++; $display("FAIL fwd_slot1_rf: got sel %0d op %h want 0", sel_a[0][1], op_a[0][1]); end checks++;
        if (stall_a[0] !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %0b want 0", stall_a[0]); end checks++;
        tick();
    endtask

    task automatic test_youngest();
        set_instr(1'b1, 7, 1'b1, 1'b0, 1, 2, 2'b11); tick();
        set_instr(1'b1, 7, 1'b1, 1'b0, 1, 2, 2'b11); tick();
        // x7 now at stages 1 and 2, x6 at stage 3.
        set_instr(1'b1, 8, 1'b1, 1'b0, 7, 6, 2'b11);
        if (sel_a[0][0] !== SW'(1) || op_a[0][0] !== SR1) begin errors++; $display("FAIL youngest_sel: got %0d %h want 1 %h", sel_a[0][0], op_a[0][0], SR1); end checks++;
        if (sel_a[0][1] !== SW'(3) || op_a[0][1] !== SR3) begin errors++; $display("FAIL oldest_stage3: got %0d %h want 3 %h", sel_a[0][1], op_a[0][1], SR3); end checks++;
        tick();
    endtask

    task automatic test_load_use();
        drain();
        set_instr(1'b1, 4, 1'b1, 1'b1, 1, 2, 2'b11); tick();
        set_instr(1'b1, 9, 1'b1, 1'b0, 1, 4, 2'b11);
        if (stall_a[0] !== 1'b1 || bub_a[0] !== 1'b1) begin errors++; $display("FAIL lu2_stall_c0: got stall %0b bubble %0b want 1 1", stall_a[0], bub_a[0]); end checks++;
        if (fde_a[0] !== 1'b0 || dee_a[0] !== 1'b1) begin errors++; $display("FAIL lu2_enables: got %0b%0b want 01", fde_a[0], dee_a[0]); end checks++;
        if (stall_a[1] !== 1'b1) begin errors++; $display("FAIL lu3_stall_c0: got %0b want 1", stall_a[1]); end checks++;
        tick();
        if (stall_a[0] !== 1'b0 || bub_a[0] !== 1'b0) begin errors++; $display("FAIL lu2_stall_c1: got stall %0b bubble %0b want 0 0", stall_a[0], bub_a[0]); end checks++;
        if (sel_a[0][1] !== SW'(2) || op_a[0][1] !== SR2) begin errors++; $display("FAIL lu2_fwd: got %0d %h want 2 %h", sel_a[0][1], op_a[0][1], SR2); end checks++;
        if (stall_a[1] !== 1'b1) begin errors++; $display("FAIL lu3_stall_c1: got %0b want 1", stall_a[1]); end checks++;
        tick();
        if (stall_a[1] !== 1'b0) begin errors++; $display("FAIL lu3_stall_c2: got %0b want 0", stall_a[1]); end checks++;
        if (sel_a[1][1] !== SW'(3) || op_a[1][1] !== SR3) begin errors++; $display("FAIL lu3_fwd: got %0d %h want 3 %h", sel_a[1][1], op_a[1][1], SR3); end checks++;
        tick();
    endtask

    task automatic test_mem_stall();
        drain();
        set_instr(1'b1, 4, 1'b1, 1'b1, 1, 2, 2'b11); tick();
        mem_ready = 1'b0;
        set_instr(1'b1, 9, 1'b1, 1'b0, 1, 4, 2'b11);
        for (int c = 0; c < 3; c++) begin
            if (stall_a[0] !== 1'b1 || bub_a[0] !== 1'b1) begin errors++; $display("FAIL mem_stall_c%0d: got stall %0b bubble %0b want 1 1", c, stall_a[0], bub_a[0]); end checks++;
            if (fde_a[0] !== 1'b0 || dee_a[0] !== 1'b0) begin errors++; $display("FAIL mem_enables_c%0d: got %0b%0b want 00", c, fde_a[0], dee_a[0]); end checks++;
            tick();
        end
        mem_ready = 1'b1; #1;
        if (stall_a[0] !== 1'b1 || dee_a[0] !== 1'b1) begin errors++; $display("FAIL mem_resume: got stall %0b d_to_e %0b want 1 1", stall_a[0], dee_a[0]); end checks++;
        tick();
        if (stall_a[0] !== 1'b0 || sel_a[0][1] !== SW'(2)) begin errors++; $display("FAIL mem_resolved: got stall %0b sel %0d want 0 2", stall_a[0], sel_a[0][1]); end checks++;
        tick();
    endtask

    task automatic test_x0_unused();
        drain();
        set_instr(1'b1, 8, 1'b1, 1'b0, 1, 2, 2'b11); tick();
        set_instr(1'b1, 0, 1'b1, 1'b0, 1, 2, 2'b11); tick();
        set_instr(1'b1, 10, 1'b0, 1'b0, 1, 2, 2'b11); tick();
        // t1 = x10 (no write), t2 = x0, t3 = x8.
        set_instr(1'b1, 11, 1'b1, 1'b0, 0, 8, 2'b01);
        if (sel_a[0][0] !== '0 || op_a[0][0] !== dec_operand[XLEN-1:0]) begin errors++; $display("FAIL x0_not_fwd: got %0d %h want 0", sel_a[0][0], op_a[0][0]); end checks++;
        if (sel_a[0][1] !== '0) begin errors++; $display("FAIL unused_slot: got %0d want 0", sel_a[0][1]); end checks++;
        set_instr(1'b1, 11, 1'b1, 1'b0, 10, 8, 2'b11);
        if (sel_a[0][0] !== '0) begin errors++; $display("FAIL no_we_not_fwd: got %0d want 0", sel_a[0][0]); end checks++;
        if (sel_a[0][1] !== SW'(3) || op_a[0][1] !== SR3) begin errors++; $display("FAIL used_slot_fwd: got %0d %h want 3 %h", sel_a[0][1], op_a[0][1], SR3); end checks++;
        tick();
    endtask

    task automatic test_flush();
        drain();
        set_instr(1'b1, 4, 1'b1, 1'b1, 1, 2, 2'b11); tick();
        flush = 1'b1;
        set_instr(1'b1, 9, 1'b1, 1'b0, 4, 2, 2'b11);
        if (stall_a[0] !== 1'b0 || bub_a[0] !== 1'b1) begin errors++; $display("FAIL flush_ctrl: got stall %0b bubble %0b want 0 1", stall_a[0], bub_a[0]); end checks++;
        if (fde_a[0] !== 1'b1) begin errors++; $display("FAIL flush_fde: got %0b want 1", fde_a[0]); end checks++;
        tick();
        flush = 1'b0;
        set_instr(1'b1, 10, 1'b1, 1'b0, 9, 4, 2'b11);
        if (sel_a[0][0] !== '0) begin errors++; $display("FAIL flush_t1_invalid: got %0d want 0", sel_a[0][0]); end checks++;
        if (sel_a[0][1] !== SW'(2) || stall_a[0] !== 1'b0) begin errors++; $display("FAIL flush_load_stage2: got sel %0d stall %0b want 2 0", sel_a[0][1], stall_a[0]); end checks++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_instr(1'b1, 4, 1'b1, 1'b1, 1, 2, 2'b11); tick();
        set_instr(1'b1, 9, 1'b1, 1'b0, 4, 2, 2'b11);
        if (stall_a[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %0b want 1", stall_a[0]); end checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        if (stall_a[0] !== 1'b0 || stall_a[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_post: got %0b/%0b want 0/0", stall_a[0], stall_a[1]); end checks++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            stage_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem_ready    = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                      2'($urandom_range(0, 3)));
            model_eval(0);
            model_eval(1);
            for (int w = 0; w < 2; w++) begin
                if (stall_a[w] !== exp_stall[w]) begin errors++; $display("FAIL rnd_stall u%0d c%0d: got %0b want %0b", w + 2, c, stall_a[w], exp_stall[w]); end checks++;
                if (bub_a[w] !== (exp_stall[w] | flush)) begin errors++; $display("FAIL rnd_bubble u%0d c%0d: got %0b want %0b", w + 2, c, bub_a[w], exp_stall[w] | flush); end checks++;
                if (fde_a[w] !== (mem_ready & ~exp_stall[w]) || dee_a[w] !== mem_ready) begin errors++; $display("FAIL rnd_enables u%0d c%0d: got %0b%0b want %0b%0b", w + 2, c, fde_a[w], dee_a[w], mem_ready & ~exp_stall[w], mem_ready); end checks++;
                for (int s = 0; s < NS; s++) begin
                    if (!exp_haz[w][s]) begin
                        if (sel_a[w][s] !== SW'(exp_sel[w][s])) begin errors++; $display("FAIL rnd_sel u%0d c%0d s%0d: got %0d want %0d", w + 2, c, s, sel_a[w][s], exp_sel[w][s]); end checks++;
                        if (op_a[w][s] !== exp_op[w][s]) begin errors++; $display("FAIL rnd_op u%0d c%0d s%0d: got %h want %h", w + 2, c, s, op_a[w][s], exp_op[w][s]); end checks++;
                    end
                end
            end
            tick();
        end
        rst = 1'b0; mem_ready = 1'b1; flush = 1'b0;
        stage_result = {SR3, SR2, SR1};
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_forward();
        test_youngest();
        test_load_use();
        test_mem_stall();
        test_x0_unused();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
